// File: rtl/uart_word_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_word_rx_if
//  Description : Word handshake between the UART word receiver (master) and
//                the downstream consumer (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_word_rx_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             word_ready;

    modport master (
        output word_out,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_out,
        input  word_valid,
        output word_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_word_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_word_rx
//  Description : 8N1 UART receiver that assembles WIDTH/8 bytes (first byte
//                in the MSBs) into one word and offers it over valid/ready.
//                Reports framing errors, overruns and inter-byte timeouts.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_word_rx #(
    parameter int CLK_HZ       = 100000000,
    parameter int BAUD         = 115200,
    parameter int WIDTH        = 16,
    parameter int TIMEOUT_BITS = 32
) (
    input  wire logic           clk,
    input  wire logic           rst,          // asynchronous, active low
    input  wire logic           rxd,
    uart_word_rx_if.master      word_if,
    output logic                frame_err,
    output logic                overrun,
    output logic                timeout_err
);

    localparam int c_CPB    = CLK_HZ / BAUD;
    localparam int c_HALF   = c_CPB / 2;
    localparam int c_NBYTES = WIDTH / 8;
    localparam int c_TO_CYC = TIMEOUT_BITS * c_CPB;
    localparam int c_CNT_W  = $clog2(c_CPB + 1);
    localparam int c_IDLE_W = $clog2(c_TO_CYC + 1);
    localparam int c_BCNT_W = $clog2(c_NBYTES + 1);

    localparam logic [c_CNT_W-1:0]  c_CPB_LAST  = c_CNT_W'(c_CPB - 1);
    localparam logic [c_CNT_W-1:0]  c_HALF_LAST = c_CNT_W'(c_HALF - 1);
    localparam logic [c_IDLE_W-1:0] c_TO_LAST   = c_IDLE_W'(c_TO_CYC - 1);
    localparam logic [c_BCNT_W-1:0] c_BCNT_LAST = c_BCNT_W'(c_NBYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_rx_meta;
    logic                r_rxs;
    logic                r_rxs_prev;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_IDLE_W-1:0] r_idle_cnt;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_shift;
    logic [WIDTH-1:0]    r_acc;
    logic [c_BCNT_W-1:0] r_byte_cnt;
    logic                r_word_done;   // last byte of a word was just accepted

    logic                w_fall;
    logic [WIDTH-1:0]    w_acc_next;

    assign w_fall = r_rxs_prev & ~r_rxs;

    // New byte enters at the LSB end so the first byte ends up in the MSBs.
    generate
        if (WIDTH > 8) begin : g_multi_byte
            assign w_acc_next = {r_acc[WIDTH-9:0], r_shift};
        end else begin : g_single_byte
            assign w_acc_next = r_shift;
        end
    endgenerate

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_meta  <= 1'b1;
            r_rxs      <= 1'b1;
            r_rxs_prev <= 1'b1;
        end else begin
            r_rx_meta  <= rxd;
            r_rxs      <= r_rx_meta;
            r_rxs_prev <= r_rxs;
        end
    end

    // Receive FSM: bit timing, byte assembly, framing and timeout handling.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idle_cnt  <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_acc       <= '0;
            r_byte_cnt  <= '0;
            r_word_done <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
            r_word_done <= 1'b0;

            // The output stage consumes the finished word this cycle.
            if (r_word_done) begin
                r_byte_cnt <= '0;
                r_acc      <= '0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state    <= S_START;
                        r_cnt      <= '0;
                        r_idle_cnt <= '0;
                    end else if ((r_byte_cnt != '0) && !r_word_done) begin
                        // A partial word waits too long for its next byte.
                        if (r_idle_cnt == c_TO_LAST) begin
                            timeout_err <= 1'b1;
                            r_acc       <= '0;
                            r_byte_cnt  <= '0;
                            r_idle_cnt  <= '0;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + 1'b1;
                        end
                    end
                end

                S_START: begin
                    if (r_cnt == c_HALF_LAST) begin
                        r_cnt <= '0;
                        if (r_rxs) begin
                            r_state <= S_IDLE;       // glitch, not a start bit
                        end else begin
                            r_state   <= S_DATA;
                            r_bit_idx <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (r_cnt == c_CPB_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {r_rxs, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_STOP: begin
                    if (r_cnt == c_CPB_LAST) begin
                        r_cnt <= '0;
                        if (r_rxs) begin
                            r_acc      <= w_acc_next;
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                            if (r_byte_cnt == c_BCNT_LAST) begin
                                r_word_done <= 1'b1;
                            end
                            r_state <= S_IDLE;
                        end else begin
                            frame_err  <= 1'b1;
                            r_acc      <= '0;
                            r_byte_cnt <= '0;
                            r_state    <= S_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_BREAK: begin
                    // Stay here until the line returns high; no phantom bytes.
                    if (r_rxs) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Output word register, valid/ready handshake and overrun detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_if.word_out   <= '0;
            word_if.word_valid <= 1'b0;
            overrun            <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (r_word_done) begin
                if (!word_if.word_valid || word_if.word_ready) begin
                    word_if.word_out   <= r_acc;
                    word_if.word_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (word_if.word_valid && word_if.word_ready) begin
                word_if.word_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_word_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_word_rx
//  Description : Self-checking bench for uart_word_rx (CPB=16, WIDTH=16).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_word_rx;

    localparam int c_CPB     = 16;
    localparam int c_WIDTH   = 16;
    localparam int c_TO_BITS = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rxd = 1'b1;
    logic frame_err;
    logic overrun;
    logic timeout_err;

    uart_word_rx_if #(.WIDTH(c_WIDTH)) wif ();

    uart_word_rx #(
        .CLK_HZ      (1600000),
        .BAUD        (100000),
        .WIDTH       (c_WIDTH),
        .TIMEOUT_BITS(c_TO_BITS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .word_if    (wif),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural model ----------------
    // Error codes: 1 frame, 2 overrun, 3 timeout.
    logic [c_WIDTH-1:0] exp_words[$];
    int                 exp_errs[$];
    logic [7:0]         acc_q[$];
    bit                 m_pending = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic m_byte(input logic [7:0] b, input bit ok);
        logic [c_WIDTH-1:0] w;
        if (!ok) begin
            exp_errs.push_back(1);
            acc_q.delete();
        end else begin
            acc_q.push_back(b);
            if (acc_q.size() == c_WIDTH / 8) begin
                w = '0;
                foreach (acc_q[i]) w = (w << 8) | c_WIDTH'(acc_q[i]);
                acc_q.delete();
                if (m_pending) begin
                    exp_errs.push_back(2);
                end else begin
                    exp_words.push_back(w);
                    m_pending = !wif.word_ready;
                end
            end
        end
    endtask

    task automatic m_idle(input int nbits);
        if (acc_q.size() > 0 && nbits >= c_TO_BITS) begin
            exp_errs.push_back(3);
            acc_q.delete();
        end
    endtask

    // ---------------- observation / compare process ----------------
    int                 n_frame = 0, n_over = 0, n_to = 0, n_words = 0, n_valid_cyc = 0;
    int                 rise_cyc = 0;
    int                 code;
    logic [c_WIDTH-1:0] last_word = '0;
    logic [c_WIDTH-1:0] prev_word = '0;
    logic               prev_valid = 1'b0;
    logic               prev_ready = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            if (frame_err || overrun || timeout_err) begin
                code = frame_err ? 1 : (overrun ? 2 : 3);
                check("pulse_exclusive", $countones({frame_err, overrun, timeout_err}), 1);
                if (code == 1) n_frame++;
                if (code == 2) n_over++;
                if (code == 3) n_to++;
                if (exp_errs.size() == 0) check("unexpected_err", code, 0);
                else                      check("err_kind", code, exp_errs.pop_front());
            end
            if (wif.word_valid && !prev_valid) rise_cyc = cyc;
            if (wif.word_valid) n_valid_cyc++;
            if (prev_valid && !prev_ready && wif.word_valid)
                check("word_stable", wif.word_out, prev_word);
            if (prev_valid && prev_ready)
                check("valid_after_accept", wif.word_valid, 0);
            if (wif.word_valid && wif.word_ready) begin
                n_words++;
                last_word = wif.word_out;
                if (exp_words.size() == 0) check("unexpected_word", 32'(wif.word_out) | 32'h1_0000, 0);
                else                       check("word", wif.word_out, exp_words.pop_front());
            end
            prev_valid = wif.word_valid;
            prev_ready = wif.word_ready;
            prev_word  = wif.word_out;
        end else begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic bit_out(input logic v);
        rxd = v;
        repeat (c_CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle_bits(input int n);
        rxd = 1'b1;
        repeat (n * c_CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
        bit_out(stop_ok);
    endtask

    task automatic send(input logic [7:0] b, input bit stop_ok);
        m_byte(b, stop_ok);
        send_byte(b, stop_ok);
    endtask

    task automatic settle(input string name);
        idle_bits(3);
        check({name, "_words_left"}, exp_words.size(), 0);
        check({name, "_errs_left"}, exp_errs.size(), 0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_word_out"}, wif.word_out, 0);
        check({name, "_word_valid"}, wif.word_valid, 0);
        check({name, "_errs"}, {frame_err, overrun, timeout_err}, 0);
    endtask

    // ---------------- directed tests ----------------
    int start_cyc;
    int base_frame, base_over, base_to, base_words, base_valid;

    task automatic snap();
        base_frame = n_frame;
        base_over  = n_over;
        base_to    = n_to;
        base_words = n_words;
        base_valid = n_valid_cyc;
    endtask

    initial begin
        wif.word_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;
        idle_bits(2);

        // 1: back-to-back bytes, ready high
        snap();
        send(8'h31, 1'b1);
        start_cyc = cyc;
        send(8'h35, 1'b1);
        settle("t1");
        check("t1_word", last_word, 16'h3135);
        check("t1_valid_cycles", n_valid_cyc - base_valid, 1);
        check("t1_no_errs", (n_frame + n_over + n_to) - (base_frame + base_over + base_to), 0);
        check("t1_latency_window", ((rise_cyc - start_cyc) >= 150) && ((rise_cyc - start_cyc) <= 162), 1);

        // 2: overrun while the first word is held
        snap();
        wif.word_ready = 1'b0;
        send(8'h31, 1'b1);
        send(8'h35, 1'b1);
        idle_bits(2);
        check("t2_held_valid", wif.word_valid, 1);
        check("t2_held_word", wif.word_out, 16'h3135);
        send(8'hAB, 1'b1);
        send(8'hCD, 1'b1);
        idle_bits(3);
        check("t2_overrun_count", n_over - base_over, 1);
        check("t2_word_kept", wif.word_out, 16'h3135);
        wif.word_ready = 1'b1;
        m_pending = 1'b0;
        @(posedge clk);
        #1;
        check("t2_valid_drop", wif.word_valid, 0);
        check("t2_accepted_word", last_word, 16'h3135);
        settle("t2");

        // 3: framing error, long break, then a good word
        snap();
        send(8'h31, 1'b0);
        repeat (50 * c_CPB) @(posedge clk);
        #1;
        idle_bits(2);
        send(8'h12, 1'b1);
        send(8'h34, 1'b1);
        settle("t3");
        check("t3_frame_count", n_frame - base_frame, 1);
        check("t3_word", last_word, 16'h1234);

        // 4: inter-byte timeout discards the partial word
        snap();
        send(8'h31, 1'b1);
        m_idle(40);
        idle_bits(40);
        send(8'h35, 1'b1);
        send(8'h36, 1'b1);
        settle("t4");
        check("t4_timeout_count", n_to - base_to, 1);
        check("t4_word", last_word, 16'h3536);

        // 5: short low glitch is ignored, receiver still works afterwards
        snap();
        rxd = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        idle_bits(3);
        check("t5_no_word", n_words - base_words, 0);
        check("t5_no_err", (n_frame + n_over + n_to) - (base_frame + base_over + base_to), 0);
        send(8'h5A, 1'b1);
        send(8'hA5, 1'b1);
        settle("t5");
        check("t5_word", last_word, 16'h5AA5);

        // 6: reset in the middle of the second byte
        send(8'h00, 1'b1);
        bit_out(1'b0);
        bit_out(1'b1);
        bit_out(1'b0);
        rst = 1'b0;
        #1;
        check_all_zero("t6_reset");
        acc_q.delete();
        m_pending = 1'b0;
        rxd = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        idle_bits(2);
        send(8'h00, 1'b1);
        send(8'h07, 1'b1);
        settle("t6");
        check("t6_word", last_word, 16'h0007);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_word_rx.md
Name: uart_word_rx

Overview:
- Serial input path for the RSA demo: receives 8N1 UART bytes on one pin and assembles WIDTH/8 bytes, MSB byte first, into one message word.
- Presents the word to the RSA encryption core over a valid/ready handshake.
- Acts as the receive-side counterpart of the display output path: it brings plaintext into the FPGA instead of the fixed key ROM.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate.
- WIDTH, 16, assembled word width; must be a multiple of 8 and at least 8.
- TIMEOUT_BITS, 32, maximum idle gap between bytes of one word, in bit times.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- rxd  input  1  UART receive line, idle high, asynchronous to clk.
- word_ready  input  1  downstream accepts word_out this cycle.
- word_out  output  WIDTH  assembled word, first-received byte in bits [WIDTH-1:WIDTH-8].
- word_valid  output  1  word_out holds a complete word.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: word completed while word_valid was still high.
- timeout_err  output  1  one-cycle pulse: partial word discarded on inter-byte timeout.

Behaviour:
- Reset values (rst low, takes effect immediately): word_out=0, word_valid=0, frame_err=0, overrun=0, timeout_err=0, FSM=IDLE, byte count=0, synchronizer flops=1.
- rxd passes through a 2-flop synchronizer; all decisions use the synchronized value rxs.
- CPB = CLK_HZ/BAUD, integer division. HALF = CPB/2. A single bit counter counts CPB clocks per bit.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: on a falling edge of rxs, go to START and clear the counter.
- START: after HALF clocks, sample rxs. If rxs=1, it is a false start: return to IDLE with no error. If rxs=0, go to DATA.
- DATA: sample 8 bits, CPB clocks apart, at bit centre, LSB first, into a shift register.
- STOP: sample CPB clocks after the last data bit.
  - If rxs=1, the byte is good: shift it into the word accumulator and increment the byte count; go to IDLE.
  - If rxs=0: pulse frame_err, discard the byte, clear the accumulator and byte count, go to BREAK.
- BREAK: wait until rxs=1, then go to IDLE. A stuck-low line never produces phantom bytes.
- Word completion: when the byte count reaches WIDTH/8 on a good stop bit, the next cycle does one of the following.
  - If word_valid=0: load word_out and set word_valid.
  - If word_valid=1 and word_ready=0 in that cycle: pulse overrun, drop the new word, keep the old word_out.
  - In both cases the byte count clears.
- Handshake: word_valid stays high and word_out stays stable until a cycle with word_valid=1 and word_ready=1; word_valid falls on the next edge.
  - Same-cycle accept and complete: a new word completing in the accepting cycle is loaded and word_valid stays high. No overrun is reported.
- Inter-byte timeout:
  - An idle counter runs in IDLE while byte count is nonzero.
  - After TIMEOUT_BITS*CPB clocks: pulse timeout_err, clear the accumulator and byte count.
  - The counter resets on any start edge.
  - Timeout is not checked while byte count is 0.
- Latency: word_valid rises 2 clocks after the cycle in which the last stop bit is sampled high (1 cycle for accumulation, 1 for the output register), plus the 2-cycle synchronizer delay from rxd.
- Error pulses are exactly one clock wide and mutually exclusive in a given cycle.
- Reset mid-frame aborts everything. The first byte after reset is received only after a fresh falling edge.

Test Plan:
- Sim params CLK_HZ=1600000, BAUD=100000 (CPB=16), WIDTH=16. Send 0x31 then 0x35 back-to-back, word_ready=1 -> word_out=0x3135, word_valid high for exactly 1 cycle, no error pulses.
- Send 0x31,0x35 with word_ready=0, then send 0xAB,0xCD -> overrun pulses once; word_out stays 0x3135. Raise word_ready -> word_valid drops next edge.
- Send 0x31 with its stop bit forced low -> frame_err pulses once. Hold rxd low 50 bit times, then release; send 0x12,0x34 -> word_out=0x1234.
- Send 0x31, idle 40 bit times -> timeout_err pulses once. Then send 0x35,0x36 -> word_out=0x3536.
- Drive a 4-clock low glitch on idle rxd -> no byte accepted, no error, FSM back in IDLE.
- Assert rst low during the DATA phase of the second byte -> all outputs 0 immediately. After release, send 0x00,0x07 -> word_out=0x0007.
